path_decision_unit: RTL
=======================

Name: path_decision_unit

Overview:
- Consumer stage directly downstream of the third BMU stage of the Viterbi decoder.
- Snapshots the eight accumulated 3-step path metrics (branch_metric_XY_Z) when valid_in is high.
- Scans them sequentially and reports the minimum-metric path as 3 decoded bits, plus the winning metric and a reliability margin (second-best minus best).
- A one-metric-per-cycle scan keeps comparator area at one 4-bit compare pair.

Parameters:
- METRIC_W, 4, width of each input path metric and of min_metric/margin outputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- refresh  input  1  synchronous clear; aborts any scan.
- valid_in  input  1  input metrics valid (from third BMU valid_out).
- branch_metric_00_0 … branch_metric_11_1  input  METRIC_W each (8 ports)  path metrics; path index = {X,Y,Z} of branch_metric_XY_Z.
- ready  output  1  high when block can accept valid_in.
- valid_out  output  1  one-cycle pulse, result outputs updated.
- decoded_bits  output  3  index {X,Y,Z} of minimum-metric path.
- min_metric  output  METRIC_W  metric of winning path.
- margin  output  METRIC_W  second-smallest metric minus min_metric.
- overrun  output  1  sticky; valid_in seen while not ready.

Behaviour:
- Reset (rst=0, async): state IDLE; valid_out=0, decoded_bits=0, min_metric=0, margin=0, overrun=0; snapshot regs and scan index 0.
- ready = (state==IDLE), combinational; it is high during and immediately after reset.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on edge with valid_in=1 and refresh=0, capture all 8 metrics into a snapshot. Initialise best=max value, second=max value, idx=0, then go to SCAN.
- SCAN: one edge per path, idx 0..7 in order 000,001,…,111.
  - If m[idx] < best: second←best, best←m[idx], best_idx←idx.
  - Else if m[idx] < second: second←m[idx].
  - Strict compare, so on ties the lower index wins and the tied value becomes second, giving margin 0.
  - After processing idx=7 (8th SCAN edge), register the outputs and go to DONE: decoded_bits←best_idx, min_metric←best, margin←second−best.
- DONE: valid_out=1 for exactly this cycle; next edge goes to IDLE with valid_out=0.
- Latency: valid_in sampled at edge E0 → valid_out high in the cycle following E8. Minimum spacing between accepted inputs is 10 cycles.
- Output hold: decoded_bits/min_metric/margin hold the last result until the next DONE, refresh, or reset.
- Arithmetic: margin is unsigned, second ≥ best, so it never wraps. All-equal metrics give index 000 and margin 0.
- Busy input: valid_in=1 while state≠IDLE is ignored (snapshot untouched) and sets overrun=1. overrun clears only on refresh or reset.
- refresh=1 (sync, highest priority after reset): next state IDLE; valid_out, outputs, and overrun cleared to 0. A valid_in in the same cycle is not captured and does not set overrun.
- Reset mid-scan: immediate return to reset values; no valid_out is produced for the aborted snapshot.
- Input metrics may change freely after capture; only the snapshot is used.

Test Plan:
- Reset, then present metrics 00_0..11_1 = 9,7,12,3,15,8,5,10 with valid_in for 1 cycle → valid_out pulse 9 edges later, decoded_bits=011, min_metric=3, margin=2, ready low for 9 cycles.
- Metrics all 6 → decoded_bits=000, min_metric=6, margin=0.
- Tie: metrics 15,15,4,15,15,4,15,15 → decoded_bits=010, min_metric=4, margin=0.
- Assert valid_in again 3 cycles after an accepted input with different metrics → first result unaffected, overrun=1 and stays 1 through a later accepted scan; refresh pulse → overrun=0.
- refresh during SCAN (edge E4) → no valid_out, outputs 0, ready=1 next cycle; a new input afterwards completes normally.
- Drive rst low mid-SCAN for 2 cycles → outputs 0 immediately (asynchronously), no valid_out; after release, back-to-back inputs spaced 10 cycles apart produce two correct results with overrun=0.

Source files
------------

// File: rtl/path_decision_unit.sv
// Viterbi path decision: snapshots eight 3-step path metrics, scans them one per cycle,
// and reports the minimum-metric path index, its metric and the margin to the runner-up.
module path_decision_unit #(
    parameter int METRIC_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refresh,
    input  logic                valid_in,
    input  logic [METRIC_W-1:0] branch_metric_00_0,
    input  logic [METRIC_W-1:0] branch_metric_00_1,
    input  logic [METRIC_W-1:0] branch_metric_01_0,
    input  logic [METRIC_W-1:0] branch_metric_01_1,
    input  logic [METRIC_W-1:0] branch_metric_10_0,
    input  logic [METRIC_W-1:0] branch_metric_10_1,
    input  logic [METRIC_W-1:0] branch_metric_11_0,
    input  logic [METRIC_W-1:0] branch_metric_11_1,
    output logic                ready,
    output logic                valid_out,
    output logic [2:0]          decoded_bits,
    output logic [METRIC_W-1:0] min_metric,
    output logic [METRIC_W-1:0] margin,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [METRIC_W-1:0] METRIC_MAX  = {METRIC_W{1'b1}};
    localparam logic [METRIC_W-1:0] METRIC_ZERO = {METRIC_W{1'b0}};

    state_t              r_state;
    state_t              w_next_state;
    logic [METRIC_W-1:0] w_in [8];
    logic [METRIC_W-1:0] r_snap [8];
    logic [2:0]          r_idx;
    logic [METRIC_W-1:0] r_best;
    logic [METRIC_W-1:0] r_second;
    logic [2:0]          r_best_idx;
    logic [METRIC_W-1:0] w_cur;
    logic [METRIC_W-1:0] w_best_nxt;
    logic [METRIC_W-1:0] w_second_nxt;
    logic [2:0]          w_best_idx_nxt;
    logic                r_valid_out;
    logic [2:0]          r_decoded_bits;
    logic [METRIC_W-1:0] r_min_metric;
    logic [METRIC_W-1:0] r_margin;
    logic                r_overrun;

    // Path index is {X,Y,Z} of branch_metric_XY_Z.
    assign w_in[0] = branch_metric_00_0;
    assign w_in[1] = branch_metric_00_1;
    assign w_in[2] = branch_metric_01_0;
    assign w_in[3] = branch_metric_01_1;
    assign w_in[4] = branch_metric_10_0;
    assign w_in[5] = branch_metric_10_1;
    assign w_in[6] = branch_metric_11_0;
    assign w_in[7] = branch_metric_11_1;

    assign w_cur        = r_snap[r_idx];
    assign ready        = (r_state == S_IDLE);
    assign valid_out    = r_valid_out;
    assign decoded_bits = r_decoded_bits;
    assign min_metric   = r_min_metric;
    assign margin       = r_margin;
    assign overrun      = r_overrun;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; refresh aborts any scan.
    always_comb begin
        w_next_state = r_state;
        if (refresh) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        w_next_state = S_SCAN;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (r_idx == 3'd7) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_SCAN;
                    end
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Strict less-than keeps the lower index on ties and pushes the tie into second.
    always_comb begin
        w_best_nxt     = r_best;
        w_second_nxt   = r_second;
        w_best_idx_nxt = r_best_idx;
        if (w_cur < r_best) begin
            w_second_nxt   = r_best;
            w_best_nxt     = w_cur;
            w_best_idx_nxt = r_idx;
        end else if (w_cur < r_second) begin
            w_second_nxt = w_cur;
        end else begin
            w_second_nxt = r_second;
        end
    end

    // Snapshot, scan accumulators, result registers and sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_snap[i] <= METRIC_ZERO;
            end
            r_idx          <= 3'd0;
            r_best         <= METRIC_ZERO;
            r_second       <= METRIC_ZERO;
            r_best_idx     <= 3'd0;
            r_valid_out    <= 1'b0;
            r_decoded_bits <= 3'd0;
            r_min_metric   <= METRIC_ZERO;
            r_margin       <= METRIC_ZERO;
            r_overrun      <= 1'b0;
        end else if (refresh) begin
            r_idx          <= 3'd0;
            r_valid_out    <= 1'b0;
            r_decoded_bits <= 3'd0;
            r_min_metric   <= METRIC_ZERO;
            r_margin       <= METRIC_ZERO;
            r_overrun      <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (valid_in && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_snap     <= w_in;
                        r_idx      <= 3'd0;
                        r_best     <= METRIC_MAX;
                        r_second   <= METRIC_MAX;
                        r_best_idx <= 3'd0;
                    end else begin
                        r_idx <= 3'd0;
                    end
                end
                S_SCAN: begin
                    r_best     <= w_best_nxt;
                    r_second   <= w_second_nxt;
                    r_best_idx <= w_best_idx_nxt;
                    r_idx      <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_valid_out    <= 1'b1;
                        r_decoded_bits <= w_best_idx_nxt;
                        r_min_metric   <= w_best_nxt;
                        r_margin       <= w_second_nxt - w_best_nxt;
                    end else begin
                        r_valid_out <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_idx <= 3'd0;
                end
                default: begin
                    r_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule
